// File: rtl/serial_adder_sequencer.sv
// Bit-serial adder: one full-adder cell, one bit per clock, LSB first.
// Valid/ready on both sides, one operation in flight.
//
// state | meaning
// IDLE  | in_ready high, waiting for operands
// RUN   | WIDTH cycles of serial add, shifting a/b/sum
// DONE  | out_valid high, result held until out_ready
module serial_adder_sequencer #(
  parameter int WIDTH = 4,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_e           state_q;
  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  logic [WIDTH-1:0] sum_sh_q;
  logic [WIDTH-1:0] sum_sh_d;
  logic [WIDTH-1:0] s_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q;
  logic             cout_q;
  logic             ovf_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             fa_s;
  logic             fa_c;

  always_comb begin
    fa_s     = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
    fa_c     = (a_sh_q[0] & b_sh_q[0]) | (carry_q & (a_sh_q[0] ^ b_sh_q[0]));
    sum_sh_d = {fa_s, sum_sh_q[WIDTH-1:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      sum_sh_q    <= '0;
      s_q         <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_sh_q     <= a;
            b_sh_q     <= b;
            carry_q    <= cin;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= RUN;
          end
        end
        RUN: begin
          a_sh_q   <= {1'b0, a_sh_q[WIDTH-1:1]};
          b_sh_q   <= {1'b0, b_sh_q[WIDTH-1:1]};
          sum_sh_q <= sum_sh_d;
          carry_q  <= fa_c;
          cnt_q    <= cnt_q + CW'(1);
          if (cnt_q == LAST_BIT) begin
            // carry_q here is still the carry into the MSB
            s_q         <= sum_sh_d;
            cout_q      <= fa_c;
            ovf_q       <= carry_q ^ fa_c;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign s         = s_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_serial_adder_sequencer.sv
// Directed bench for serial_adder_sequencer (WIDTH=4) with a result scoreboard.
module tb_serial_adder_sequencer;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] a;
  logic [3:0] b;
  logic       cin;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] s;
  logic       cout;
  logic       ovf;

  int         n_chk;
  int         n_fail;
  logic [5:0] exp_q[$];
  logic [5:0] exp_r;
  logic [3:0] ba [3];
  logic [3:0] bb [3];
  int         acc_t [3];
  int         n_acc;
  int         n_res;
  int         cyc;
  int         lat;

  serial_adder_sequencer #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .cout      (cout),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {s, cout, ovf}
  function automatic logic [5:0] model(input logic [3:0] ma, input logic [3:0] mb,
                                       input logic mc);
    logic [4:0] full;
    logic       v;
    full = {1'b0, ma} + {1'b0, mb} + {4'b0, mc};
    v    = (ma[3] == mb[3]) && (full[3] != ma[3]);
    return {full[3:0], full[4], v};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic pop_exp();
    check("scoreboard_nonempty", 32'(exp_q.size() > 0), 32'd1);
    if (exp_q.size() > 0) exp_r = exp_q.pop_front();
    else exp_r = 6'h3f;
  endtask

  task automatic check_result(input string tag);
    check({tag, "_s"},    32'(s),    32'(exp_r[5:2]));
    check({tag, "_cout"}, 32'(cout), 32'(exp_r[1]));
    check({tag, "_ovf"},  32'(ovf),  32'(exp_r[0]));
  endtask

  // Called at the negedge right after the accept edge.
  task automatic finish_op(input string tag);
    lat = 0;
    while (!out_valid && lat < 20) begin
      check({tag, "_busy_in_ready"}, 32'(in_ready), 32'd0);
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'd4);
    check({tag, "_done_in_ready"}, 32'(in_ready), 32'd0);
    pop_exp();
    check_result(tag);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check({tag, "_out_valid_drop"}, 32'(out_valid), 32'd0);
    check({tag, "_in_ready_back"}, 32'(in_ready), 32'd1);
  endtask

  task automatic do_op(input string tag, input logic [3:0] ta, input logic [3:0] tb_b,
                       input logic tc);
    @(negedge clk);
    a = ta; b = tb_b; cin = tc; in_valid = 1'b1; out_ready = 1'b1;
    check({tag, "_in_ready_idle"}, 32'(in_ready), 32'd1);
    exp_q.push_back(model(ta, tb_b, tc));
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a = 4'($urandom); b = 4'($urandom); cin = 1'($urandom);
    finish_op(tag);
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b0;
    ba[0] = 4'd1; ba[1] = 4'd15; ba[2] = 4'd6;
    bb[0] = 4'd1; bb[1] = 4'd1;  bb[2] = 4'd6;
    repeat (2) @(negedge clk);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_s",         32'(s),         32'd0);
    check("rst_cout",      32'(cout),      32'd0);
    check("rst_ovf",       32'(ovf),       32'd0);
    rst_n = 1'b1;

    do_op("ucarry", 4'b0111, 4'b1001, 1'b0);
    do_op("sovf_pos", 4'b0101, 4'b0100, 1'b0);
    do_op("sovf_neg", 4'b1000, 4'b1000, 1'b0);

    for (int i = 0; i < 512; i++)
      do_op("sweep", 4'(i >> 5), 4'(i >> 1), 1'(i));

    // Backpressure with a new request pending
    @(negedge clk);
    a = 4'd3; b = 4'd5; cin = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    exp_q.push_back(model(4'd3, 4'd5, 1'b1));
    @(posedge clk);
    @(negedge clk);
    a = 4'd2; b = 4'd2; cin = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      check("bp_busy_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
      lat++;
    end
    check("bp_latency", 32'(lat), 32'd4);
    pop_exp();
    for (int i = 0; i < 5; i++) begin
      check("bp_hold_out_valid", 32'(out_valid), 32'd1);
      check("bp_hold_in_ready",  32'(in_ready),  32'd0);
      check_result("bp_hold");
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_release_out_valid", 32'(out_valid), 32'd0);
    check("bp_release_in_ready",  32'(in_ready),  32'd1);
    exp_q.push_back(model(4'd2, 4'd2, 1'b0));
    @(posedge clk);
    @(negedge clk);
    check("bp_second_taken", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    finish_op("bp_second");

    // Reset in the middle of RUN, counter at 2
    @(negedge clk);
    a = 4'd9; b = 4'd9; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_in_ready",  32'(in_ready),  32'd1);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_s",         32'(s),         32'd0);
    check("midrst_cout",      32'(cout),      32'd0);
    check("midrst_ovf",       32'(ovf),       32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op("post_rst", 4'b0011, 4'b0001, 1'b0);

    // Back-to-back with in_valid and out_ready held high
    n_acc = 0; n_res = 0; cyc = 0;
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; a = ba[0]; b = bb[0]; cin = 1'b0;
    while (n_res < 3 && cyc < 100) begin
      if (in_valid && in_ready) begin
        exp_q.push_back(model(a, b, cin));
        acc_t[n_acc] = cyc;
        n_acc++;
      end
      if (out_valid) begin
        pop_exp();
        check_result("b2b");
        n_res++;
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (n_acc < 3) begin
        a = ba[n_acc]; b = bb[n_acc];
      end else begin
        in_valid = 1'b0;
      end
    end
    check("b2b_results", 32'(n_res), 32'd3);
    check("b2b_accepts", 32'(n_acc), 32'd3);
    if (n_acc == 3) begin
      check("b2b_spacing01", 32'(acc_t[1] - acc_t[0]), 32'd6);
      check("b2b_spacing12", 32'(acc_t[2] - acc_t[1]), 32'd6);
    end
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
